// File: rtl/fetch_unit.sv
// Instruction fetch stage: sequential imem requests, in-order prefetch FIFO,
// redirect flush with discard of in-flight responses.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0080_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] LIMIT = (CW + 1)'(DEPTH);

    logic [31:0]   fetch_pc;
    logic [31:0]   buf_pc    [DEPTH];
    logic [31:0]   buf_instr [DEPTH];
    logic [31:0]   pcq       [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] q_head;
    logic [AW-1:0] q_tail;
    logic [CW-1:0] count;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] discard;

    logic [CW:0]   credit;
    logic [CW-1:0] outstanding_next;
    logic          req_fire;
    logic          push;
    logic          pop;

    // Buffered plus in-flight never exceeds DEPTH, so a response always has room.
    assign credit         = {1'b0, count} + {1'b0, outstanding};
    assign imem_req_valid = reset_n && (credit < LIMIT);
    assign imem_req_addr  = fetch_pc;
    assign req_fire       = imem_req_valid && imem_req_ready;

    assign outstanding_next = outstanding + CW'(req_fire) - CW'(imem_rsp_valid);

    assign push = imem_rsp_valid && (discard == '0) && !redirect_valid;
    assign pop  = if_valid && if_ready;

    assign if_valid = (count != '0);
    assign if_instr = if_valid ? buf_instr[head] : 32'h0;
    assign if_pc    = if_valid ? buf_pc[head]    : 32'h0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            fetch_pc    <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            q_head      <= '0;
            q_tail      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (req_fire) begin
                pcq[q_tail] <= fetch_pc;
                q_tail      <= q_tail + 1'b1;
            end
            if (imem_rsp_valid) begin
                q_head <= q_head + 1'b1;
            end
            if (redirect_valid) begin
                // Every request still in flight after this edge is stale.
                fetch_pc <= {redirect_pc[31:2], 2'b00};
                head     <= '0;
                tail     <= '0;
                count    <= '0;
                discard  <= outstanding_next;
            end else begin
                if (req_fire) begin
                    fetch_pc <= fetch_pc + 32'd4;
                end
                if (imem_rsp_valid && (discard != '0)) begin
                    discard <= discard - 1'b1;
                end
                if (push) begin
                    buf_pc[tail]    <= pcq[q_head];
                    buf_instr[tail] <= imem_rsp_data;
                    tail            <= tail + 1'b1;
                end
                if (pop) begin
                    head <= head + 1'b1;
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: memory model with variable latency,
// expected {pc, instr} queued at request accept and compared on pop.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0080_0000;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        redirect_valid;
    logic [31:0] redirect_pc;

    logic        w_req_valid;
    logic [31:0] w_req_addr;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [31:0] w_if_pc;
    logic        w_one  = 1'b1;
    logic        w_zero = 1'b0;
    logic [31:0] w_zdat = 32'h0;

    always #5 clk = ~clk;

    fetch_unit u_dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) u_wrap (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req_valid (w_req_valid),
        .imem_req_addr  (w_req_addr),
        .imem_req_ready (w_one),
        .imem_rsp_valid (w_zero),
        .imem_rsp_data  (w_zdat),
        .if_valid       (w_if_valid),
        .if_instr       (w_if_instr),
        .if_pc          (w_if_pc),
        .if_ready       (w_zero),
        .redirect_valid (w_zero),
        .redirect_pc    (w_zdat)
    );

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    mreq_t       mq[$];
    exp_t        sb[$];
    logic [31:0] wq[$];

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc = 0;
    int          lat = 1;
    int          nacc = 0;
    int          npop = 0;
    logic [31:0] mpc = RST_PC;
    logic        rst = 1'b0;
    logic        rq_rdy = 1'b1;
    logic        if_rdy = 1'b1;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        got_first = 1'b0;
    logic [31:0] first_pc = 32'h0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive at negedge, then sample and update the models.
    task automatic step();
        exp_t e;
        @(negedge clk);
        cyc++;
        reset_n        = rst;
        if_ready       = if_rdy;
        imem_req_ready = rq_rdy;
        redirect_valid = redir;
        redirect_pc    = redir_pc;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if (!rst) begin
            mq.delete();
            sb.delete();
            mpc = RST_PC;
        end else if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end
        #1;
        if (!rst) return;
        if (w_req_valid && wq.size() < 3) wq.push_back(w_req_addr);
        if (if_valid && if_ready) begin
            npop++;
            if (sb.size() == 0) begin
                check("pop_unexpected", if_pc, 32'hDEAD_DEAD);
            end else begin
                e = sb.pop_front();
                check("if_pc", if_pc, e.pc);
                check("if_instr", if_instr, e.instr);
                if (!got_first) begin
                    got_first = 1'b1;
                    first_pc  = if_pc;
                end
            end
        end
        if (imem_req_valid) check("req_addr", imem_req_addr, mpc);
        if (imem_req_valid && imem_req_ready) begin
            nacc++;
            mq.push_back('{imem_req_addr, cyc + lat});
            if (!redir) sb.push_back('{mpc, mem_word(mpc)});
            mpc += 32'd4;
        end
        if (redir) begin
            sb.delete();
            mpc = {redir_pc[31:2], 2'b00};
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    logic [31:0] wexp [3];

    initial begin
        wexp[0] = 32'hFFFF_FFF8;
        wexp[1] = 32'hFFFF_FFFC;
        wexp[2] = 32'h0000_0000;
        reset_n = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'h0;
        if_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'h0;

        step();
        step();
        @(posedge clk);
        #1;
        check("rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("rst_if_valid", 32'(if_valid), 32'd0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_pc", if_pc, 32'h0);

        rst = 1'b1;
        npop = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 0) check("first_req_valid", 32'(imem_req_valid), 32'd1);
            if (i == 0) check("first_req_addr", imem_req_addr, RST_PC);
            if (i >= 2) check("stream_valid", 32'(if_valid), 32'd1);
        end
        check("stream_pops", 32'(npop), 32'd18);

        check("wrap_count", 32'(wq.size()), 32'd3);
        for (int k = 0; k < wq.size(); k++) check("wrap_addr", wq[k], wexp[k]);

        do_reset();
        if_rdy = 1'b0;
        nacc = 0;
        for (int i = 0; i < 12; i++) step();
        check("bp_accepts", 32'(nacc), 32'd4);
        check("bp_req_valid", 32'(imem_req_valid), 32'd0);
        check("bp_if_valid", 32'(if_valid), 32'd1);
        check("bp_if_pc", if_pc, RST_PC);
        if_rdy = 1'b1;
        npop = 0;
        for (int i = 0; i < 4; i++) step();
        check("drain_pops", 32'(npop), 32'd4);
        for (int i = 0; i < 8; i++) step();

        do_reset();
        lat = 3;
        rq_rdy = 1'b1;
        step();
        step();
        rq_rdy = 1'b0;
        redir = 1'b1;
        redir_pc = 32'h0090_0002;
        step();
        redir = 1'b0;
        rq_rdy = 1'b1;
        got_first = 1'b0;
        step();
        check("rd_if_valid", 32'(if_valid), 32'd0);
        check("rd_req_valid", 32'(imem_req_valid), 32'd1);
        check("rd_req_addr", imem_req_addr, 32'h0090_0000);
        for (int i = 0; i < 15; i++) step();
        check("rd_first_seen", 32'(got_first), 32'd1);
        check("rd_first_pc", first_pc, 32'h0090_0000);

        do_reset();
        lat = 1;
        for (int i = 0; i < 6; i++) step();
        redir = 1'b1;
        redir_pc = 32'h00A0_0010;
        step();
        redir = 1'b0;
        got_first = 1'b0;
        step();
        check("rs_if_valid", 32'(if_valid), 32'd0);
        for (int i = 0; i < 12; i++) step();
        check("rs_first_pc", first_pc, 32'h00A0_0010);
        lat = 2;
        for (int i = 0; i < 30; i++) begin
            if_rdy = 1'($urandom_range(0, 1));
            redir = (i == 15);
            redir_pc = 32'h00B0_0006;
            step();
        end
        redir = 1'b0;
        if_rdy = 1'b1;
        for (int i = 0; i < 10; i++) step();

        do_reset();
        lat = 1;
        if_rdy = 1'b0;
        for (int i = 0; i < 10; i++) step();
        check("full_if_valid", 32'(if_valid), 32'd1);
        rst = 1'b0;
        step();
        @(posedge clk);
        #1;
        check("mid_rst_if_valid", 32'(if_valid), 32'd0);
        check("mid_rst_req_valid", 32'(imem_req_valid), 32'd0);
        check("mid_rst_if_pc", if_pc, 32'h0);
        rst = 1'b1;
        if_rdy = 1'b1;
        step();
        check("mid_rst_req_addr", imem_req_addr, RST_PC);
        for (int i = 0; i < 10; i++) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
